// File: rtl/scr1_pipe_mprf_wb.sv
// EXU-side register file controller: write-back arbitration for ALU/LSU/MDU,
// the pending-write scoreboard behind issue interlocks, and operand forwarding.
module scr1_pipe_mprf_wb #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              iss_vd,
  output logic              iss_rdy,
  input  logic [ADDR_W-1:0] iss_rs1_addr,
  input  logic [ADDR_W-1:0] iss_rs2_addr,
  input  logic              iss_rd_we,
  input  logic [ADDR_W-1:0] iss_rd_addr,
  output logic [XLEN-1:0]   opnd_rs1_data,
  output logic [XLEN-1:0]   opnd_rs2_data,

  input  logic              alu_vd,
  output logic              alu_rdy,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_vd,
  output logic              lsu_rdy,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              mdu_vd,
  output logic              mdu_rdy,
  input  logic [ADDR_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]   mdu_data,

  output logic [ADDR_W-1:0] wb2mprf_rs1_addr,
  output logic [ADDR_W-1:0] wb2mprf_rs2_addr,
  input  logic [XLEN-1:0]   mprf2wb_rs1_data,
  input  logic [XLEN-1:0]   mprf2wb_rs2_data,
  output logic              wb2mprf_w_req,
  output logic [ADDR_W-1:0] wb2mprf_rd_addr,
  output logic [XLEN-1:0]   wb2mprf_rd_data
);

  localparam int NSLOT = 1 << ADDR_W;

  // Scoreboard slots that can ever be pending: x0 and addresses beyond NREG stay zero.
  function automatic logic [NSLOT-1:0] writableMask();
    logic [NSLOT-1:0] m;
    for (int i = 0; i < NSLOT; i++) m[i] = (i > 0) && (i < NREG);
    return m;
  endfunction

  localparam logic [NSLOT-1:0] WRITABLE = writableMask();

  logic [NSLOT-1:0]  pend_q, pend_d;
  logic              wb_req_q, wb_req_d;
  logic [ADDR_W-1:0] wb_rd_addr_q, wb_rd_addr_d;
  logic [XLEN-1:0]   wb_rd_data_q, wb_rd_data_d;

  logic              hazard;
  logic              iss_set;
  logic              any_vd;
  logic              gnt_alu, gnt_lsu, gnt_mdu;
  logic [ADDR_W-1:0] gnt_rd;
  logic [XLEN-1:0]   gnt_data;

  always_comb begin
    hazard  = pend_q[iss_rs1_addr] | pend_q[iss_rs2_addr]
            | (iss_rd_we & pend_q[iss_rd_addr]);
    iss_set = iss_vd & ~hazard & iss_rd_we & (iss_rd_addr != '0);
  end

  assign iss_rdy = ~hazard;

  // Fixed priority LSU > MDU > ALU; with nothing offered every source sees ready.
  always_comb begin
    any_vd  = alu_vd | lsu_vd | mdu_vd;
    gnt_lsu = lsu_vd;
    gnt_mdu = mdu_vd & ~lsu_vd;
    gnt_alu = alu_vd & ~lsu_vd & ~mdu_vd;
    gnt_rd   = alu_rd;
    gnt_data = alu_data;
    if (gnt_lsu) begin
      gnt_rd   = lsu_rd;
      gnt_data = lsu_data;
    end else if (gnt_mdu) begin
      gnt_rd   = mdu_rd;
      gnt_data = mdu_data;
    end
  end

  assign alu_rdy = gnt_alu | ~any_vd;
  assign lsu_rdy = gnt_lsu | ~any_vd;
  assign mdu_rdy = gnt_mdu | ~any_vd;

  // The set is applied after the clear so a same-register collision leaves it pending.
  always_comb begin
    pend_d = pend_q;
    if (any_vd) pend_d[gnt_rd] = 1'b0;
    if (iss_set) pend_d[iss_rd_addr] = 1'b1;
    pend_d = pend_d & WRITABLE;

    wb_req_d     = any_vd & (gnt_rd != '0);
    wb_rd_addr_d = any_vd ? gnt_rd   : wb_rd_addr_q;
    wb_rd_data_d = any_vd ? gnt_data : wb_rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= '0;
      wb_req_q     <= 1'b0;
      wb_rd_addr_q <= '0;
      wb_rd_data_q <= '0;
    end else begin
      pend_q       <= pend_d;
      wb_req_q     <= wb_req_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_data_q <= wb_rd_data_d;
    end
  end

  always_comb begin
    opnd_rs1_data = mprf2wb_rs1_data;
    if (iss_rs1_addr == '0)
      opnd_rs1_data = '0;
    else if (wb_req_q && (wb_rd_addr_q == iss_rs1_addr))
      opnd_rs1_data = wb_rd_data_q;

    opnd_rs2_data = mprf2wb_rs2_data;
    if (iss_rs2_addr == '0)
      opnd_rs2_data = '0;
    else if (wb_req_q && (wb_rd_addr_q == iss_rs2_addr))
      opnd_rs2_data = wb_rd_data_q;
  end

  assign wb2mprf_rs1_addr = iss_rs1_addr;
  assign wb2mprf_rs2_addr = iss_rs2_addr;
  assign wb2mprf_w_req    = wb_req_q;
  assign wb2mprf_rd_addr  = wb_rd_addr_q;
  assign wb2mprf_rd_data  = wb_rd_data_q;

  function automatic logic addrLegal(input logic [ADDR_W-1:0] a);
    return (a == '0) | WRITABLE[a];
  endfunction

  a_result_pending: assert property (@(posedge clk) disable iff (!rst_n)
    (any_vd && (gnt_rd != '0)) |-> pend_q[gnt_rd]);

  a_issue_addr_legal: assert property (@(posedge clk) disable iff (!rst_n)
    iss_vd |-> (addrLegal(iss_rs1_addr) && addrLegal(iss_rs2_addr)
                && (!iss_rd_we || addrLegal(iss_rd_addr))));

  a_result_addr_legal: assert property (@(posedge clk) disable iff (!rst_n)
    any_vd |-> addrLegal(gnt_rd));

endmodule

// File: tb/tb_scr1_pipe_mprf_wb.sv
// Bench for scr1_pipe_mprf_wb: directed cycle table, reset-in-flight sequence,
// and a randomized run against an architectural scoreboard model.
module tb_scr1_pipe_mprf_wb;

  logic        clk, rst_n;
  logic        iss_vd, iss_rdy, iss_rd_we;
  logic [4:0]  iss_rs1_addr, iss_rs2_addr, iss_rd_addr;
  logic [31:0] opnd_rs1_data, opnd_rs2_data;
  logic        alu_vd, alu_rdy, lsu_vd, lsu_rdy, mdu_vd, mdu_rdy;
  logic [4:0]  alu_rd, lsu_rd, mdu_rd;
  logic [31:0] alu_data, lsu_data, mdu_data;
  logic [4:0]  wb2mprf_rs1_addr, wb2mprf_rs2_addr, wb2mprf_rd_addr;
  logic [31:0] mprf2wb_rs1_data, mprf2wb_rs2_data, wb2mprf_rd_data;
  logic        wb2mprf_w_req;

  logic [31:0] mem [32];
  logic [31:0] initPattern [32];
  logic        preloadReq;
  int          total, bad;

  scr1_pipe_mprf_wb #(.XLEN(32), .ADDR_W(5), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_vd(iss_vd), .iss_rdy(iss_rdy),
    .iss_rs1_addr(iss_rs1_addr), .iss_rs2_addr(iss_rs2_addr),
    .iss_rd_we(iss_rd_we), .iss_rd_addr(iss_rd_addr),
    .opnd_rs1_data(opnd_rs1_data), .opnd_rs2_data(opnd_rs2_data),
    .alu_vd(alu_vd), .alu_rdy(alu_rdy), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_vd(lsu_vd), .lsu_rdy(lsu_rdy), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .mdu_vd(mdu_vd), .mdu_rdy(mdu_rdy), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .wb2mprf_rs1_addr(wb2mprf_rs1_addr), .wb2mprf_rs2_addr(wb2mprf_rs2_addr),
    .mprf2wb_rs1_data(mprf2wb_rs1_data), .mprf2wb_rs2_data(mprf2wb_rs2_data),
    .wb2mprf_w_req(wb2mprf_w_req), .wb2mprf_rd_addr(wb2mprf_rd_addr),
    .wb2mprf_rd_data(wb2mprf_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural MPRF: asynchronous read, write committed on the edge after w_req.
  assign mprf2wb_rs1_data = mem[wb2mprf_rs1_addr];
  assign mprf2wb_rs2_data = mem[wb2mprf_rs2_addr];

  always @(posedge clk) begin
    if (preloadReq)
      for (int i = 0; i < 32; i++) mem[i] <= initPattern[i];
    else if (wb2mprf_w_req)
      mem[wb2mprf_rd_addr] <= wb2mprf_rd_data;
  end

  typedef struct {
    logic [31:0] issVd, rs1, rs2, we, rd;
    logic [31:0] aluVd, aluRd, aluData;
    logic [31:0] lsuVd, lsuRd, lsuData;
    logic [31:0] mduVd, mduRd, mduData;
    logic [31:0] expIss, expRdy, expWReq, expWAddr, expWData;
    logic [31:0] chkOp, expOp1, expOp2;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    iss_vd = v.issVd[0]; iss_rs1_addr = v.rs1[4:0]; iss_rs2_addr = v.rs2[4:0];
    iss_rd_we = v.we[0]; iss_rd_addr = v.rd[4:0];
    alu_vd = v.aluVd[0]; alu_rd = v.aluRd[4:0]; alu_data = v.aluData;
    lsu_vd = v.lsuVd[0]; lsu_rd = v.lsuRd[4:0]; lsu_data = v.lsuData;
    mdu_vd = v.mduVd[0]; mdu_rd = v.mduRd[4:0]; mdu_data = v.mduData;
  endtask

  task automatic checkRow(input vec_t v, input int idx);
    checkOutput($sformatf("row%0d iss_rdy", idx), {31'd0, iss_rdy}, v.expIss);
    checkOutput($sformatf("row%0d src_rdy", idx), {29'd0, mdu_rdy, lsu_rdy, alu_rdy}, v.expRdy);
    checkOutput($sformatf("row%0d w_req", idx), {31'd0, wb2mprf_w_req}, v.expWReq);
    if (v.expWReq[0]) begin
      checkOutput($sformatf("row%0d w_addr", idx), {27'd0, wb2mprf_rd_addr}, v.expWAddr);
      checkOutput($sformatf("row%0d w_data", idx), wb2mprf_rd_data, v.expWData);
    end
    if (v.chkOp[0]) begin
      checkOutput($sformatf("row%0d opnd1", idx), opnd_rs1_data, v.expOp1);
      checkOutput($sformatf("row%0d opnd2", idx), opnd_rs2_data, v.expOp2);
    end
  endtask

  task automatic idleInputs();
    vec_t z;
    z = '{default: 32'd0};
    applyStimulus(z);
  endtask

  // Random-phase reference model: architectural values and outstanding writes.
  logic [31:0] mVal [32];
  bit          mPend [32];
  bit          mOwned [32];
  logic        sVd [3];
  logic [4:0]  sRd [3];
  logic [31:0] sData [3];
  int          lastGrant;
  logic        expWReq;
  logic [4:0]  expWAddr;
  logic [31:0] expWData;

  task automatic driveSources();
    alu_vd = sVd[0]; alu_rd = sRd[0]; alu_data = sData[0];
    lsu_vd = sVd[1]; lsu_rd = sRd[1]; lsu_data = sData[1];
    mdu_vd = sVd[2]; mdu_rd = sRd[2]; mdu_data = sData[2];
  endtask

  task automatic randomCycle(input int cyc);
    bit   haz, found;
    int   g, start, r;
    logic [31:0] e1, e2;
    @(posedge clk); #1;
    if (lastGrant >= 0) sVd[lastGrant] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (!sVd[s] && $urandom_range(2) == 0) begin
        if ($urandom_range(9) == 0) begin
          sVd[s] = 1'b1; sRd[s] = 5'd0; sData[s] = $urandom;
        end else begin
          found = 1'b0;
          start = $urandom_range(31);
          for (int k = 0; k < 32; k++) begin
            r = (start + k) % 32;
            if (!found && r != 0 && mPend[r] && !mOwned[r]) begin
              found = 1'b1; mOwned[r] = 1'b1;
              sVd[s] = 1'b1; sRd[s] = 5'(r); sData[s] = $urandom;
            end
          end
        end
      end
    end
    driveSources();
    iss_vd       = 1'($urandom_range(1));
    iss_rs1_addr = 5'($urandom_range(11));
    iss_rs2_addr = 5'($urandom_range(11));
    iss_rd_addr  = 5'($urandom_range(11));
    iss_rd_we    = 1'($urandom_range(1));

    @(negedge clk);
    haz = mPend[iss_rs1_addr] || mPend[iss_rs2_addr] || (iss_rd_we && mPend[iss_rd_addr]);
    g = sVd[1] ? 1 : sVd[2] ? 2 : sVd[0] ? 0 : -1;
    checkOutput($sformatf("rnd%0d iss_rdy", cyc), {31'd0, iss_rdy}, {31'd0, !haz});
    checkOutput($sformatf("rnd%0d src_rdy", cyc), {29'd0, mdu_rdy, lsu_rdy, alu_rdy},
                {29'd0, (g < 0 || g == 2), (g < 0 || g == 1), (g < 0 || g == 0)});
    checkOutput($sformatf("rnd%0d w_req", cyc), {31'd0, wb2mprf_w_req}, {31'd0, expWReq});
    if (expWReq) begin
      checkOutput($sformatf("rnd%0d w_addr", cyc), {27'd0, wb2mprf_rd_addr}, {27'd0, expWAddr});
      checkOutput($sformatf("rnd%0d w_data", cyc), wb2mprf_rd_data, expWData);
    end
    if (!haz) begin
      e1 = (iss_rs1_addr == 0) ? 32'd0 : mVal[iss_rs1_addr];
      e2 = (iss_rs2_addr == 0) ? 32'd0 : mVal[iss_rs2_addr];
      checkOutput($sformatf("rnd%0d opnd1", cyc), opnd_rs1_data, e1);
      checkOutput($sformatf("rnd%0d opnd2", cyc), opnd_rs2_data, e2);
    end

    expWReq = (g >= 0) && (sRd[g] != 0);
    if (g >= 0) begin
      expWAddr = sRd[g];
      expWData = sData[g];
      if (sRd[g] != 0) begin
        mPend[sRd[g]] = 0; mOwned[sRd[g]] = 0; mVal[sRd[g]] = sData[g];
      end
    end
    lastGrant = g;
    if (iss_vd && !haz && iss_rd_we && iss_rd_addr != 0) mPend[iss_rd_addr] = 1;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    preloadReq = 1'b1;
    for (int i = 0; i < 32; i++) initPattern[i] = 32'h1000_0000 + i;
    initPattern[0] = 32'hBAD0_BAD0;
    idleInputs();

    //        vd rs1 rs2 we rd | alu vd,rd,data     | lsu vd,rd,data | mdu vd,rd,data   | iss rdy   wreq,addr,data      | chk op1 op2
    vecs[0]  = '{1, 3, 0, 1, 5,  0, 0, 0,             0, 0, 0,        0, 0, 0,           1, 'b111, 0, 0, 0,              1, 'h10000003, 'h0};
    vecs[0].rs2 = 4; vecs[0].expOp2 = 'h10000004;
    vecs[1]  = '{1, 5, 0, 0, 0,  0, 0, 0,             0, 0, 0,        0, 0, 0,           0, 'b111, 0, 0, 0,              0, 0, 0};
    vecs[2]  = '{1, 5, 0, 0, 0,  1, 5, 'hDEADBEEF,    0, 0, 0,        0, 0, 0,           0, 'b001, 0, 0, 0,              0, 0, 0};
    vecs[3]  = '{1, 5, 0, 0, 0,  0, 0, 0,             0, 0, 0,        0, 0, 0,           1, 'b111, 1, 5, 'hDEADBEEF,     1, 'hDEADBEEF, 0};
    vecs[4]  = '{1, 5, 0, 1, 6,  0, 0, 0,             0, 0, 0,        0, 0, 0,           1, 'b111, 0, 0, 0,              1, 'hDEADBEEF, 0};
    vecs[5]  = '{1, 0, 0, 1, 7,  0, 0, 0,             0, 0, 0,        0, 0, 0,           1, 'b111, 0, 0, 0,              1, 0, 0};
    vecs[6]  = '{1, 0, 0, 1, 8,  0, 0, 0,             0, 0, 0,        0, 0, 0,           1, 'b111, 0, 0, 0,              0, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 0,  1, 8, 'h33,          1, 6, 'h11,     1, 7, 'h22,        1, 'b010, 0, 0, 0,              0, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 0,  1, 8, 'h33,          0, 0, 0,        1, 7, 'h22,        1, 'b100, 1, 6, 'h11,           0, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 0,  1, 8, 'h33,          0, 0, 0,        0, 0, 0,           1, 'b001, 1, 7, 'h22,           0, 0, 0};
    vecs[10] = '{0, 6, 7, 0, 0,  0, 0, 0,             0, 0, 0,        0, 0, 0,           1, 'b111, 1, 8, 'h33,           1, 'h11, 'h22};
    vecs[11] = '{1, 8, 0, 1, 9,  0, 0, 0,             0, 0, 0,        0, 0, 0,           1, 'b111, 0, 0, 0,              1, 'h33, 0};
    vecs[12] = '{1, 0, 0, 1, 9,  0, 0, 0,             0, 0, 0,        0, 0, 0,           0, 'b111, 0, 0, 0,              0, 0, 0};
    vecs[13] = '{1, 0, 0, 1, 9,  1, 9, 'hCAFEF00D,    0, 0, 0,        0, 0, 0,           0, 'b001, 0, 0, 0,              0, 0, 0};
    vecs[14] = '{1, 0, 0, 1, 9,  0, 0, 0,             0, 0, 0,        0, 0, 0,           1, 'b111, 1, 9, 'hCAFEF00D,     1, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 0,  0, 0, 0,             0, 0, 0,        1, 0, 'hFFFFFFFF,  1, 'b100, 0, 0, 0,              1, 0, 0};
    vecs[16] = '{0, 9, 0, 0, 0,  0, 0, 0,             0, 0, 0,        0, 0, 0,           0, 'b111, 0, 0, 0,              0, 0, 0};
    vecs[17] = '{1, 0, 0, 1, 10, 1, 9, 'h12345678,    0, 0, 0,        0, 0, 0,           1, 'b001, 0, 0, 0,              0, 0, 0};
    vecs[18] = '{0, 10, 0, 0, 0, 0, 0, 0,             0, 0, 0,        0, 0, 0,           0, 'b111, 1, 9, 'h12345678,     0, 0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset w_req", {31'd0, wb2mprf_w_req}, 32'd0);
    checkOutput("reset w_addr", {27'd0, wb2mprf_rd_addr}, 32'd0);
    checkOutput("reset w_data", wb2mprf_rd_data, 32'd0);
    checkOutput("reset iss_rdy", {31'd0, iss_rdy}, 32'd1);
    checkOutput("reset src_rdy", {29'd0, mdu_rdy, lsu_rdy, alu_rdy}, 32'd7);
    @(posedge clk); #1;
    rst_n = 1'b1;
    preloadReq = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkRow(vecs[i], i);
    end

    // Reset lands while x10 is pending and the x9 write is still in the wb register.
    rst_n = 1'b0;
    #1;
    checkOutput("rst async w_req", {31'd0, wb2mprf_w_req}, 32'd0);
    checkOutput("rst async iss_rdy", {31'd0, iss_rdy}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleInputs();
    iss_rs1_addr = 5'd10; iss_rs2_addr = 5'd9; iss_rd_we = 1'b1; iss_rd_addr = 5'd10;
    @(negedge clk);
    checkOutput("post-rst iss_rdy", {31'd0, iss_rdy}, 32'd1);
    checkOutput("post-rst opnd x10", opnd_rs1_data, 32'h1000_000A);
    checkOutput("post-rst dropped x9", opnd_rs2_data, 32'hCAFEF00D);

    @(posedge clk); #1;
    idleInputs();
    for (int i = 0; i < 32; i++) begin
      initPattern[i] = $urandom;
      mVal[i] = initPattern[i];
      mPend[i] = 0;
      mOwned[i] = 0;
    end
    for (int s = 0; s < 3; s++) begin
      sVd[s] = 1'b0; sRd[s] = 5'd0; sData[s] = 32'd0;
    end
    lastGrant = -1;
    expWReq = 1'b0; expWAddr = 5'd0; expWData = 32'd0;
    preloadReq = 1'b1;
    @(posedge clk); #1;
    preloadReq = 1'b0;

    for (int c = 0; c < 600; c++) randomCycle(c);

    $display("[TB] random phase complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scr1_pipe_mprf_wb.md
Name: scr1_pipe_mprf_wb

Overview:
- EXU-side controller that drives the multi-port register file (MPRF) interface: operand reads plus the single write port.
- Owns the write-back arbiter for three result sources (ALU, LSU, MDU), a per-register pending scoreboard, and operand forwarding from the registered write-back stage.
- Holds instruction issue while a source or destination register has an outstanding write (RAW/WAW).

Parameters:
- XLEN, 32, data width.
- ADDR_W, 5, register address width (4 when RVE is configured).
- NREG, 32, architectural register count (16 for RVE); register 0 is hardwired zero.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- iss_vd  in  1  issue request valid
- iss_rdy  out  1  issue accepted (no hazard)
- iss_rs1_addr  in  ADDR_W  source 1 address
- iss_rs2_addr  in  ADDR_W  source 2 address
- iss_rd_we  in  1  instruction writes rd
- iss_rd_addr  in  ADDR_W  destination address
- opnd_rs1_data  out  XLEN  forwarded source 1 operand
- opnd_rs2_data  out  XLEN  forwarded source 2 operand
- alu_vd / lsu_vd / mdu_vd  in  1  result valid, one per source
- alu_rdy / lsu_rdy / mdu_rdy  out  1  result accepted, one per source
- alu_rd / lsu_rd / mdu_rd  in  ADDR_W  result destination
- alu_data / lsu_data / mdu_data  in  XLEN  result data
- wb2mprf_rs1_addr  out  ADDR_W  MPRF read address 1 (= iss_rs1_addr)
- wb2mprf_rs2_addr  out  ADDR_W  MPRF read address 2 (= iss_rs2_addr)
- mprf2wb_rs1_data  in  XLEN  MPRF read data 1
- mprf2wb_rs2_data  in  XLEN  MPRF read data 2
- wb2mprf_w_req  out  1  MPRF write request
- wb2mprf_rd_addr  out  ADDR_W  MPRF write address
- wb2mprf_rd_data  out  XLEN  MPRF write data

Behaviour:
- Reset (async, any cycle):
  - Scoreboard is cleared.
  - wb_req, wb_rd_addr and wb_rd_data registers go to 0.
  - With the scoreboard clear, iss_rdy=1 and all *_rdy follow arbitration.
  - A write in flight when reset asserts is dropped.
- Scoreboard: pend[1..NREG-1]. pend[0] is constant 0.
- Issue hazard, evaluated combinationally: hazard = pend[rs1] | pend[rs2] | (iss_rd_we & pend[rd]).
  - iss_rdy = ~hazard, independent of iss_vd.
  - Accepted issue is iss_vd & iss_rdy.
- Pending set: on an accepted issue with iss_rd_we=1 and rd≠0, set pend[rd] at the clock edge.
- Arbitration (combinational): fixed priority LSU > MDU > ALU, one grant per cycle.
  - The granted source sees *_rdy=1; all others see 0.
  - A source must hold vd, rd and data until rdy.
  - With no vd asserted, every *_rdy=1.
- Write-back register: on a grant, the next edge loads wb_req=1 with the granted rd and data; otherwise wb_req=0.
  - Same edge clears pend[granted rd].
  - wb2mprf_* are driven directly from these registers.
  - The MPRF commits the write one cycle later, so total latency from result handshake to architectural visibility is 2 edges.
- A result with rd=0 is accepted and consumes the slot, but drives wb_req=0 and clears nothing.
- Forwarding: opnd_rsN_data =
  - 0 if rsN=0;
  - else wb2mprf_rd_data if wb_req & (wb_rd_addr==rsN);
  - else mprf2wb_rsN_data.
- A result granted in cycle T is forwardable in cycle T+1. In cycle T itself pend is still set, so issue stalls.
- Simultaneous issue set and grant clear on the same register cannot occur, because a pending rd blocks issue. If it does occur, set wins.
- A result whose rd is not pending is still written. A simulation-only assertion flags it.
- All address comparisons use full ADDR_W. Addresses ≥ NREG are illegal and flagged by assertion.

Test Plan:
- Reset, then issue rs1=3, rs2=4, rd=5, we=1 -> iss_rdy=1; pend[5]=1 next cycle. A following issue with rs1=5 sees iss_rdy=0.
- alu_vd with rd=5, data=0xDEADBEEF -> alu_rdy=1; next cycle wb2mprf_w_req=1, rd_addr=5, rd_data=0xDEADBEEF. The stalled issue with rs1=5 now has iss_rdy=1 and opnd_rs1_data=0xDEADBEEF via forwarding.
- lsu_vd (rd=6, 0x11), mdu_vd (rd=7, 0x22) and alu_vd (rd=8, 0x33) in the same cycle -> writes on three consecutive cycles in order 6, 7, 8. alu_rdy stays 0 for 2 cycles while alu_data is held.
- WAW: rd=9 pending, issue rd=9 we=1 with rs1=rs2=0 -> iss_rdy=0 until the result for 9 is granted.
- Result with rd=0 and data 0xFFFFFFFF -> wb2mprf_w_req stays 0; opnd for rs=0 reads 0.
- Assert rst_n low while pend[10]=1 and wb_req=1 -> w_req=0 immediately, scoreboard cleared, iss_rdy=1 after release.
